inst_loader_fetch: RTL

Instruction-memory front end of the multi-cycle CPU, directly upstream of the fd pipeline register.
- LOAD mode: consumes the byte stream from uart_rx. Parses a 4-byte word-count header, then packs the following program bytes into 32-bit big-endian words and writes them to an internal instruction BRAM. Signals done when the last word has been written.
- EXEC mode: returns the instruction at the byte-addressed pc with one-cycle registered latency.

---
 rtl/inst_loader_fetch_if.sv | 57 +++++
 rtl/inst_loader_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/inst_loader_fetch_if.sv
// Bus between the CPU control/UART side and the instruction loader/fetch unit.
// Groups the byte-stream input, the fetch address/data pair and the load
// status outputs so the block can be connected with a single port.
interface inst_loader_fetch_if #(
  parameter int ADDR_W = 15
);

  // Byte stream handshake: rx_valid is a one-cycle pulse qualifying rx_data
  // and rx_ferr on the same clock edge. There is no ready/back-pressure; the
  // loader either accepts the byte on that edge or drops it silently, so the
  // producer never waits and never repeats a byte.
  logic [2:0]        mode;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ferr;

  // Fetch port: pc sampled on an edge, inst valid after that edge.
  logic [31:0]       pc;
  logic [31:0]       inst;

  // Load status.
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  // Loader state, exported for observation.
  logic [2:0]        state_dbg;

  // Driver side: CPU control, UART receiver and fetch stage.
  modport master (
    output mode,
    output rx_data,
    output rx_valid,
    output rx_ferr,
    output pc,
    input  inst,
    input  done,
    input  err,
    input  word_count,
    input  state_dbg
  );

  // The loader/fetch block itself.
  modport slave (
    input  mode,
    input  rx_data,
    input  rx_valid,
    input  rx_ferr,
    input  pc,
    output inst,
    output done,
    output err,
    output word_count,
    output state_dbg
  );

endinterface

// File: rtl/inst_loader_fetch.sv
// Instruction-memory front end of the multi-cycle CPU.
// LOAD mode: parses a 4-byte big-endian word-count header from the UART byte
// stream, then packs the following bytes into 32-bit big-endian words and
// writes them to the instruction BRAM. EXEC (and every other) mode: the BRAM
// read port returns mem[pc] with one cycle of registered latency.
module inst_loader_fetch #(
  parameter int ADDR_W = 15
) (
  input  logic                 clk,
  input  logic                 rstn,
  inst_loader_fetch_if.slave   bus
);

  localparam int          DEPTH   = 2 ** ADDR_W;
  // Depth widened to 33 bits so a full 32-bit header compares without wrap.
  localparam logic [32:0] DEPTH_W = 33'(1) << ADDR_W;

  localparam logic [2:0]  MODE_LOAD = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_BODY = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Loader registers.
  state_t              state_q;
  logic [1:0]          byte_cnt_q;
  logic [ADDR_W-1:0]   widx_q;
  logic [23:0]         shift_q;
  logic                done_q;
  logic                err_q;
  logic [ADDR_W:0]     word_count_q;

  // Fetch registers and storage.
  logic [31:0]         inst_q;
  logic [31:0]         mem_q [DEPTH];

  // Combinational decode of the current byte.
  logic                load_mode;
  logic                rx_state;
  logic                byte_take;
  logic                ferr_hit;
  logic                word_end;
  logic [31:0]         word_d;
  logic                hdr_zero;
  logic                hdr_big;
  logic                last_word;
  logic                mem_we;
  logic [ADDR_W-1:0]   rd_addr;
  logic                unused_pc;

  assign load_mode = (bus.mode == MODE_LOAD);
  assign rx_state  = (state_q == S_HDR) || (state_q == S_BODY);

  // A byte is consumed only in LOAD mode while the parser is collecting;
  // anything else on the stream (idle, terminal states, other modes) is lost.
  assign byte_take = bus.rx_valid && load_mode && rx_state && !bus.rx_ferr;
  assign ferr_hit  = bus.rx_valid && load_mode && rx_state &&  bus.rx_ferr;
  assign word_end  = byte_take && (byte_cnt_q == 2'd3);

  // Word completed by the byte arriving now: earlier bytes are the high bits.
  assign word_d    = {shift_q, bus.rx_data};

  // Header classification, meaningful only on the header's 4th byte.
  assign hdr_zero  = (word_d == 32'd0);
  assign hdr_big   = ({1'b0, word_d} > DEPTH_W);

  // Body termination: the word being written now is the last announced one.
  assign last_word = ({1'b0, widx_q} == (word_count_q - (ADDR_W+1)'(1)));

  // The write lands on the same edge that accepts the word's 4th byte.
  assign mem_we    = word_end && (state_q == S_BODY);

  // Byte address to word address; low two bits and the bits above the array
  // are dropped, so fetches wrap modulo the memory depth.
  assign rd_addr   = bus.pc[ADDR_W+1:2];
  assign unused_pc = ^{bus.pc[31:ADDR_W+2], bus.pc[1:0]};

  // Loader FSM: header parse, body packing, terminal DONE/ERR; all outputs registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      widx_q       <= '0;
      shift_q      <= 24'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_mode) begin
            state_q <= S_HDR;
          end
        end

        S_HDR: begin
          if (ferr_hit) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else if (byte_take) begin
            shift_q    <= word_d[23:0];
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (hdr_zero) begin
                word_count_q <= '0;
                done_q       <= 1'b1;
                state_q      <= S_DONE;
              end else if (hdr_big) begin
                word_count_q <= '1;
                err_q        <= 1'b1;
                state_q      <= S_ERR;
              end else begin
                word_count_q <= word_d[ADDR_W:0];
                widx_q       <= '0;
                state_q      <= S_BODY;
              end
            end
          end
        end

        S_BODY: begin
          if (ferr_hit) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else if (byte_take) begin
            shift_q    <= word_d[23:0];
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              widx_q <= widx_q + 1'b1;
              if (last_word) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end
          end
        end

        // DONE and ERR hold everything until reset.
        S_DONE: state_q <= S_DONE;
        S_ERR:  state_q <= S_ERR;

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Instruction memory write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[widx_q] <= word_d;
    end
  end

  // Instruction memory read port: registered, read-first against the write port.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      inst_q <= 32'd0;
    end else begin
      inst_q <= mem_q[rd_addr];
    end
  end

  assign bus.inst       = inst_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.word_count = word_count_q;
  assign bus.state_dbg  = state_q;

endmodule
